// File: rtl/color_quant_pipe.sv
// color_quant_pipe
// Two-stage pipelined per-channel colour reduction. Each channel keeps a
// runtime-programmable number of MSBs, either truncated or rounded to nearest
// with saturation. Reduction settings are double-buffered: writes land in a
// shadow bank and are copied to the active bank by an accepted start-of-frame.
//
// Optional feature macro: COLOR_QUANT_STATS_EN adds the sat_count port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_sof marks first pixel of a frame
//   in_data               NUM_CH x CH_W pixel, channel 0 in the LSBs
//   out_valid/out_ready   output handshake; out_sof travels with the pixel
//   out_data              reduced pixel
//   cfg_we/cfg_ch         shadow write strobe and channel index (>=NUM_CH ignored)
//   cfg_bits/cfg_round    kept MSB count (clamped to CH_W), 0=truncate 1=round
//   sat_count             (stats build) round-mode saturations this frame
module color_quant_pipe #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  localparam int CW  = $clog2(CH_W + 1),
  localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DW  = NUM_CH * CH_W,
  localparam int SCW = $clog2(NUM_CH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic [DW-1:0] out_data,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_ch,
  input  logic [CW-1:0] cfg_bits,
  input  logic          cfg_round
`ifdef COLOR_QUANT_STATS_EN
  ,
  output logic [15:0]   sat_count
`endif
);

  function automatic logic [CW-1:0] clampBits(input logic [CW-1:0] b);
    logic [CW-1:0] r;
    if (int'(b) > CH_W) r = CW'(CH_W);
    else                r = b;
    return r;
  endfunction

  // Top k bits set.
  function automatic logic [CH_W-1:0] topMask(input logic [CW-1:0] k);
    logic [CH_W-1:0] m;
    for (int i = 0; i < CH_W; i++) m[i] = (i >= CH_W - int'(k));
    return m;
  endfunction

  // x + half an LSB of the kept field, one bit wider to expose overflow.
  function automatic logic [CH_W:0] roundSum(input logic [CH_W-1:0] x, input logic [CW-1:0] k);
    logic [CH_W:0] h;
    for (int i = 0; i <= CH_W; i++) h[i] = (i == CH_W - int'(k) - 1);
    return {1'b0, x} + h;
  endfunction

  function automatic logic isPartial(input logic [CW-1:0] k);
    return (k != {CW{1'b0}}) && (int'(k) < CH_W);
  endfunction

  function automatic logic [CH_W-1:0] quantize(input logic [CH_W-1:0] x,
                                               input logic [CW-1:0] k, input logic rnd);
    logic [CH_W-1:0] mask;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] y;
    mask = topMask(k);
    sum  = roundSum(x, k);
    if (k == {CW{1'b0}})  y = {CH_W{1'b0}};
    else if (int'(k) >= CH_W) y = x;
    else if (rnd) begin
      if (sum[CH_W]) y = mask;
      else           y = sum[CH_W-1:0] & mask;
    end
    else y = x & mask;
    return y;
  endfunction

  function automatic logic satEvent(input logic [CH_W-1:0] x, input logic [CW-1:0] k,
                                    input logic rnd);
    logic [CH_W:0] sum;
    sum = roundSum(x, k);
    return rnd && isPartial(k) && sum[CH_W];
  endfunction

  logic [CW-1:0]     shadowBits_r [NUM_CH];
  logic [NUM_CH-1:0] shadowRound_r;
  logic [CW-1:0]     activeBits_r [NUM_CH];
  logic [NUM_CH-1:0] activeRound_r;
  logic [CW-1:0]     nextShadowBits_s [NUM_CH];
  logic [NUM_CH-1:0] nextShadowRound_s;
  logic [CW-1:0]     beatBits_s [NUM_CH];
  logic [NUM_CH-1:0] beatRound_s;

  logic              v1_r, sof1_r, v2_r, sof2_r;
  logic [DW-1:0]     x1_r, y2_r, quantPix_s;
  logic [CW-1:0]     bits1_r [NUM_CH];
  logic [NUM_CH-1:0] round1_r;
  logic              en1_s, en2_s, inAccept_s;

  assign en2_s      = ~v2_r | out_ready;
  assign en1_s      = ~v1_r | en2_s;
  assign in_ready   = en1_s;
  assign inAccept_s = in_valid & en1_s;
  assign out_valid  = v2_r;
  assign out_data   = y2_r;
  assign out_sof    = sof2_r;

  // Shadow after this cycle's write; an sof beat uses it directly so a
  // same-cycle write applies to that beat.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nextShadowBits_s[c]  = shadowBits_r[c];
      nextShadowRound_s[c] = shadowRound_r[c];
      if (cfg_we && (int'(cfg_ch) == c)) begin
        nextShadowBits_s[c]  = clampBits(cfg_bits);
        nextShadowRound_s[c] = cfg_round;
      end else begin
        nextShadowBits_s[c]  = shadowBits_r[c];
        nextShadowRound_s[c] = shadowRound_r[c];
      end
      if (in_sof) begin
        beatBits_s[c]  = nextShadowBits_s[c];
        beatRound_s[c] = nextShadowRound_s[c];
      end else begin
        beatBits_s[c]  = activeBits_r[c];
        beatRound_s[c] = activeRound_r[c];
      end
    end
  end

  // Shadow and active config banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadowBits_r[c] <= CW'(CH_W);
        activeBits_r[c] <= CW'(CH_W);
      end
      shadowRound_r <= {NUM_CH{1'b0}};
      activeRound_r <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) shadowBits_r[c] <= nextShadowBits_s[c];
      shadowRound_r <= nextShadowRound_s;
      if (inAccept_s && in_sof) begin
        for (int c = 0; c < NUM_CH; c++) activeBits_r[c] <= nextShadowBits_s[c];
        activeRound_r <= nextShadowRound_s;
      end else begin
        activeRound_r <= activeRound_r;
      end
    end
  end

  // Per-channel reduction of the S1 beat.
  always_comb begin
    quantPix_s = {DW{1'b0}};
    for (int c = 0; c < NUM_CH; c++)
      quantPix_s[c*CH_W +: CH_W] = quantize(x1_r[c*CH_W +: CH_W], bits1_r[c], round1_r[c]);
  end

  // S1 captures pixel plus its own config; S2 holds the reduced result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r     <= 1'b0;
      sof1_r   <= 1'b0;
      x1_r     <= {DW{1'b0}};
      round1_r <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) bits1_r[c] <= CW'(CH_W);
      v2_r     <= 1'b0;
      sof2_r   <= 1'b0;
      y2_r     <= {DW{1'b0}};
    end else begin
      if (en1_s) begin
        v1_r <= in_valid;
        if (in_valid) begin
          x1_r     <= in_data;
          sof1_r   <= in_sof;
          round1_r <= beatRound_s;
          for (int c = 0; c < NUM_CH; c++) bits1_r[c] <= beatBits_s[c];
        end
      end
      if (en2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          y2_r   <= quantPix_s;
          sof2_r <= sof1_r;
        end
      end
    end
  end

`ifdef COLOR_QUANT_STATS_EN
  logic [SCW-1:0] satIn_s, satS1_s;
  logic [16:0]    satSum_s;
  logic [15:0]    satCount_r;

  // Saturation counts for the incoming beat and for the beat leaving S1.
  always_comb begin
    satIn_s = {SCW{1'b0}};
    satS1_s = {SCW{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      satIn_s = satIn_s + SCW'(satEvent(in_data[c*CH_W +: CH_W], beatBits_s[c], beatRound_s[c]));
      satS1_s = satS1_s + SCW'(satEvent(x1_r[c*CH_W +: CH_W], bits1_r[c], round1_r[c]));
    end
    satSum_s = {1'b0, satCount_r} + 17'(satS1_s);
  end

  // An sof beat restarts the count with its own events at entry, so it is
  // skipped when it later leaves S1; an older beat leaving in that same cycle
  // belongs to the previous frame and is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) satCount_r <= 16'h0000;
    else if (inAccept_s && in_sof) satCount_r <= 16'(satIn_s);
    else if (en2_s && v1_r && !sof1_r) satCount_r <= satSum_s[16] ? 16'hFFFF : satSum_s[15:0];
    else satCount_r <= satCount_r;
  end

  assign sat_count = satCount_r;
`endif

endmodule
